// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants and helpers for the keypad scanner
// Purpose: 4x4 legend codes, scan FSM state encodings, index-to-legend
//          mapping and output code width helper.
// Ports:   none (package).
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_STAR = 4'd15;

  // IDLE only exists while in reset, so the rows stay released until the
  // first clock edge after rst_n deasserts.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;

  // Matrix index (row*4 + col) to the printed legend of the 4x4 keypad.
  function automatic logic [3:0] legend_of(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = KEY_1;
      4'd1:    code = KEY_2;
      4'd2:    code = KEY_3;
      4'd3:    code = KEY_A;
      4'd4:    code = KEY_4;
      4'd5:    code = KEY_5;
      4'd6:    code = KEY_6;
      4'd7:    code = KEY_B;
      4'd8:    code = KEY_7;
      4'd9:    code = KEY_8;
      4'd10:   code = KEY_9;
      4'd11:   code = KEY_C;
      4'd12:   code = KEY_STAR;
      4'd13:   code = KEY_0;
      4'd14:   code = KEY_HASH;
      default: code = KEY_D;
    endcase
    return code;
  endfunction

  function automatic int code_width(input int rows, input int cols);
    int w;
    w = $clog2(rows * cols);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - key event handshake and status bundle
// Purpose: carries key events (code/release with valid/ready) and the
//          held/multi status from the scanner to its consumer.
// Ports:   master = scanner side, slave = consumer side.
interface keypad_scanner_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] key_code;
  logic              key_release;
  logic              key_valid;
  logic              key_ready;
  logic              multi;
  logic              held;

  modport master (
    output key_code, key_release, key_valid, multi, held,
    input  key_ready
  );

  modport slave (
    input  key_code, key_release, key_valid, multi, held,
    output key_ready
  );
endinterface

// File: rtl/keypad_frame_debounce.sv
// rtl/keypad_frame_debounce.sv - whole-frame debouncer for the key matrix
// Purpose: accepts a new matrix state once DEBOUNCE_FRAMES identical
//          consecutive frames have been seen.
// Ports:   clk, rst_n, frame_strobe (frame_in complete), frame_in,
//          accepted (debounced state S).
module keypad_frame_debounce #(
  parameter int KEYS            = 16,
  parameter int DEBOUNCE_FRAMES = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frame_strobe,
  input  logic [KEYS-1:0] frame_in,
  output logic [KEYS-1:0] accepted
);

  localparam logic [3:0] SAT = 4'(DEBOUNCE_FRAMES);
  // The counter counts matches against the previous frame, so N identical
  // frames in a row leave it at N-1; DEBOUNCE_FRAMES=1 accepts every frame.
  localparam logic [3:0] ACCEPT_AT = 4'(DEBOUNCE_FRAMES - 1);

  logic [KEYS-1:0] prev_frame;
  logic [3:0]      match_cnt;
  logic [3:0]      match_cnt_next;

  always_comb begin
    match_cnt_next = 4'd0;
    if (frame_in == prev_frame) begin
      match_cnt_next = (match_cnt >= SAT) ? SAT : match_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_frame <= '0;
      match_cnt  <= 4'd0;
      accepted   <= '0;
    end else if (frame_strobe) begin
      prev_frame <= frame_in;
      match_cnt  <= match_cnt_next;
      if (match_cnt_next >= ACCEPT_AT) begin
        accepted <= frame_in;
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - row-scanning matrix keypad controller
// Purpose: drives rows one at a time, senses columns, debounces whole
//          frames and reports press/release events one per frame.
// Ports:   clk, rst_n (async active-low), row (active-low drive),
//          col (active-low sense, async), evt (event/status interface).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int DWELL_CYCLES    = 50000,
  parameter int DEBOUNCE_FRAMES = 5,
  parameter int LEGACY_MAP      = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [ROWS-1:0] row,
  input  logic [COLS-1:0] col,
  keypad_scanner_if.master evt
);

  localparam int KEYS   = ROWS * COLS;
  localparam int CODE_W = code_width(ROWS, COLS);
  localparam int DW_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int RW     = $clog2(ROWS);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam bit USE_LEGEND = (LEGACY_MAP != 0) && (ROWS == 4) && (COLS == 4);

  logic [COLS-1:0] col_meta;
  logic [COLS-1:0] col_sync;
  logic [1:0]      state;
  logic [RW-1:0]   row_idx;
  logic [DW_W-1:0] dwell_cnt;
  logic [KEYS-1:0] frame;
  logic [KEYS-1:0] frame_next;
  logic [KEYS-1:0] s_map;
  logic [KEYS-1:0] r_map;
  logic            last_dwell;
  logic            frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  assign last_dwell = (state == ST_DRIVE) && (dwell_cnt == DWELL_LAST);
  assign frame_done = last_dwell && (row_idx == ROW_LAST);

  // Merge the current row into the frame on its last dwell cycle; the
  // debouncer sees the completed frame combinationally so S is already
  // up to date in the FRAME cycle that follows.
  always_comb begin
    frame_next = frame;
    if (last_dwell) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_idx == RW'(r)) begin
          frame_next[r*COLS +: COLS] = ~col_sync;
        end
      end
    end
  end

  always_comb begin
    row = '1;
    if (state == ST_DRIVE) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_idx == RW'(r)) begin
          row[r] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      row_idx   <= '0;
      dwell_cnt <= '0;
      frame     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state     <= ST_DRIVE;
          row_idx   <= '0;
          dwell_cnt <= '0;
        end
        ST_DRIVE: begin
          frame <= frame_next;
          if (last_dwell) begin
            dwell_cnt <= '0;
            if (row_idx == ROW_LAST) begin
              state <= ST_FRAME;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        ST_FRAME: begin
          state   <= ST_DRIVE;
          row_idx <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  keypad_frame_debounce #(
    .KEYS            (KEYS),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_strobe (frame_done),
    .frame_in     (frame_next),
    .accepted     (s_map)
  );

  assign evt.held  = |s_map;
  assign evt.multi = |(s_map & (s_map - 1'b1));

  logic [KEYS-1:0]   diff;
  logic [KEYS-1:0]   sel_mask;
  logic [CODE_W-1:0] sel_idx;
  logic [CODE_W-1:0] sel_code;
  logic              sel_found;
  logic              out_free;

  // Lowest differing index between accepted and reported maps.
  always_comb begin
    diff      = s_map ^ r_map;
    sel_mask  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = 0; i < KEYS; i++) begin
      if (diff[i] && !sel_found) begin
        sel_found   = 1'b1;
        sel_mask[i] = 1'b1;
        sel_idx     = CODE_W'(i);
      end
    end
    if (USE_LEGEND) begin
      sel_code = CODE_W'(legend_of(sel_idx[3:0]));
    end else begin
      sel_code = sel_idx;
    end
  end

  assign out_free = !evt.key_valid || evt.key_ready;

  // A stalled consumer simply leaves the S/R difference in place; it is
  // picked up again at the next FRAME cycle, so nothing is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_map           <= '0;
      evt.key_valid   <= 1'b0;
      evt.key_code    <= '0;
      evt.key_release <= 1'b0;
    end else if ((state == ST_FRAME) && sel_found && out_free) begin
      evt.key_code    <= sel_code;
      evt.key_release <= |(r_map & sel_mask);
      evt.key_valid   <= 1'b1;
      r_map           <= r_map ^ sel_mask;
    end else if (evt.key_valid && evt.key_ready) begin
      evt.key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner
module tb_keypad_scanner;

  localparam int FR = 17;  // 4 rows * 4 dwell + 1 frame cycle

  typedef struct {
    logic [3:0] code;
    logic       rel;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] keys;

  ev_t exp_q[$];
  int  checks;
  int  errors;

  keypad_scanner_if #(.CODE_W(4)) evt ();

  keypad_scanner #(
    .ROWS            (4),
    .COLS            (4),
    .DWELL_CYCLES    (4),
    .DEBOUNCE_FRAMES (3),
    .LEGACY_MAP      (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row   (row),
    .col   (col),
    .evt   (evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && keys[r*4+c]) col[c] = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] code, input logic rel);
    ev_t e;
    e.code = code;
    e.rel  = rel;
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (evt.key_valid) begin
        seen = 1;
        break;
      end
      cycles(1);
    end
    chk(name, seen, 1);
  endtask

  // Monitor: pops the scoreboard on every handshake and checks the
  // per-cycle row and stall-stability properties.
  logic       have_prev;
  logic       prev_valid, prev_ready, prev_rel;
  logic [3:0] prev_code;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
    end else begin
      int zeros;
      zeros = 0;
      for (int r = 0; r < 4; r++) if (!row[r]) zeros++;
      checks++;
      if (zeros > 1) begin
        errors++;
        $display("FAIL row_onehot: row=%b has %0d zero bits, allowed at most 1", row, zeros);
      end
      if (have_prev && prev_valid && !prev_ready) begin
        checks++;
        if (!evt.key_valid || evt.key_code != prev_code || evt.key_release != prev_rel) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b code=%0d rel=%0b expected v=1 code=%0d rel=%0b",
                   evt.key_valid, evt.key_code, evt.key_release, prev_code, prev_rel);
        end
      end
      if (evt.key_valid && evt.key_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got code=%0d rel=%0b expected no event",
                   evt.key_code, evt.key_release);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (evt.key_code != e.code || evt.key_release != e.rel) begin
            errors++;
            $display("FAIL event: got code=%0d rel=%0b expected code=%0d rel=%0b",
                     evt.key_code, evt.key_release, e.code, e.rel);
          end
        end
      end
      have_prev  = 1'b1;
      prev_valid = evt.key_valid;
      prev_ready = evt.key_ready;
      prev_code  = evt.key_code;
      prev_rel   = evt.key_release;
    end
  end

  initial begin
    checks        = 0;
    errors        = 0;
    have_prev     = 1'b0;
    rst_n         = 1'b0;
    keys          = 16'h0000;
    evt.key_ready = 1'b1;
    cycles(3);

    chk("rst_row",     int'(row), 15);
    chk("rst_valid",   int'(evt.key_valid), 0);
    chk("rst_code",    int'(evt.key_code), 0);
    chk("rst_release", int'(evt.key_release), 0);
    chk("rst_held",    int'(evt.held), 0);
    chk("rst_multi",   int'(evt.multi), 0);

    @(negedge clk);
    rst_n = 1'b1;
    cycles(1);
    chk("first_drive_row0", int'(row), 14);
    cycles(3 * FR);

    // Single key row1/col2 (legend 6): press then release.
    push(4'd6, 1'b0);
    keys[6] = 1'b1;
    cycles(6 * FR);
    chk("k6_held", int'(evt.held), 1);
    chk("k6_multi", int'(evt.multi), 0);
    push(4'd6, 1'b1);
    keys[6] = 1'b0;
    cycles(6 * FR);
    chk("k6_released_held", int'(evt.held), 0);

    // Bounce on row0/col0: toggling every 5 cycles never gives three
    // identical frames, so nothing is accepted.
    for (int t = 0; t < 12; t++) begin
      keys[0] = ~keys[0];
      cycles(5);
    end
    keys[0] = 1'b0;
    cycles(6 * FR);
    chk("bounce_held", int'(evt.held), 0);
    chk("bounce_queue", exp_q.size(), 0);

    // Two keys at once: index 5 (code 5) then index 15 (code 13).
    push(4'd5, 1'b0);
    push(4'd13, 1'b0);
    keys[5]  = 1'b1;
    keys[15] = 1'b1;
    cycles(7 * FR);
    chk("dual_multi", int'(evt.multi), 1);
    chk("dual_held", int'(evt.held), 1);
    push(4'd5, 1'b1);
    push(4'd13, 1'b1);
    keys[5]  = 1'b0;
    keys[15] = 1'b0;
    cycles(7 * FR);
    chk("dual_multi_off", int'(evt.multi), 0);
    chk("dual_queue", exp_q.size(), 0);

    // Stalled consumer: key 1 held pending; a full press/release of key 3
    // during the stall vanishes; key 2 follows once ready returns.
    evt.key_ready = 1'b0;
    push(4'd1, 1'b0);
    keys[0] = 1'b1;
    cycles(10 * FR);
    chk("stall_valid", int'(evt.key_valid), 1);
    chk("stall_code", int'(evt.key_code), 1);
    chk("stall_release", int'(evt.key_release), 0);
    keys[2] = 1'b1;
    cycles(6 * FR);
    keys[2] = 1'b0;
    cycles(6 * FR);
    push(4'd2, 1'b0);
    keys[1] = 1'b1;
    cycles(6 * FR);
    chk("stall_code_kept", int'(evt.key_code), 1);
    evt.key_ready = 1'b1;
    cycles(3 * FR);
    push(4'd2, 1'b1);
    keys[1] = 1'b0;
    cycles(6 * FR);
    push(4'd1, 1'b1);
    keys[0] = 1'b0;
    cycles(6 * FR);
    chk("stall_queue", exp_q.size(), 0);

    // Reset while an event is pending.
    evt.key_ready = 1'b0;
    push(4'd9, 1'b0);
    keys[10] = 1'b1;
    wait_valid("rst_pending_valid");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_valid",   int'(evt.key_valid), 0);
    chk("midrst_code",    int'(evt.key_code), 0);
    chk("midrst_release", int'(evt.key_release), 0);
    chk("midrst_held",    int'(evt.held), 0);
    chk("midrst_multi",   int'(evt.multi), 0);
    chk("midrst_row",     int'(row), 15);
    cycles(3);
    keys          = 16'h0000;
    evt.key_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(8 * FR);
    chk("post_rst_held", int'(evt.held), 0);
    chk("post_rst_valid", int'(evt.key_valid), 0);
    chk("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of matrix rows driven (2..8).
REQ-002 Parameter COLS, default 4, number of matrix columns sensed (2..8).
REQ-003 Parameter DWELL_CYCLES, default 50000, clk cycles each row is driven (1 ms at 50 MHz).
REQ-004 Parameter DEBOUNCE_FRAMES, default 5, consecutive identical full-matrix frames before a state is accepted (1..15).
REQ-005 Parameter LEGACY_MAP, default 1, when 1 and ROWS=COLS=4, key_code uses the team 4x4 legend, otherwise the raw index.
REQ-006 Derived CODE_W = max(4, clog2(ROWS*COLS)).
REQ-007 clk  in  1  single system clock, all logic on rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 row  out  ROWS  row drive, active-low, at most one bit low.
REQ-010 col  in  COLS  column sense, active-low, externally pulled up, asynchronous to clk.
REQ-011 key_code  out  CODE_W  code of the reported key.
REQ-012 key_release  out  1  event type: 0 = press, 1 = release.
REQ-013 key_valid  out  1  event available.
REQ-014 key_ready  in  1  consumer accepts the event.
REQ-015 multi  out  1  more than one key held in the accepted state.
REQ-016 held  out  1  at least one key held in the accepted state.

Function
REQ-017 The scan FSM SHALL have states DRIVE and FRAME; DRIVE holds row r low for DWELL_CYCLES cycles, r = 0..ROWS-1.
REQ-018 The FSM SHALL pass col through a 2-flop synchroniser and sample it into frame bit (r, c) on the last DWELL cycle of row r; active-low col maps to 1 = pressed.
REQ-019 After row ROWS-1, the FSM SHALL spend exactly one cycle in FRAME with all row bits high, then return to DRIVE with r = 0.
REQ-020 The debouncer SHALL increment a frame-match counter when the new frame equals the previous one and reset it to 0 otherwise, saturating at DEBOUNCE_FRAMES.
REQ-021 The accepted state S SHALL load the frame when the counter reaches DEBOUNCE_FRAMES; DEBOUNCE_FRAMES=1 accepts every frame.
REQ-022 The block SHALL keep a reported map R, and in each FRAME cycle select the lowest index i = r*COLS + c with S[i] != R[i].
REQ-023 If an index is selected and the output register is free (key_valid=0, or key_valid=1 and key_ready=1 in the same cycle), the block SHALL load key_code, set key_release = R[i], assert key_valid the next cycle, and toggle R[i].
REQ-024 If the output is not free, no event SHALL be lost; the difference persists in S vs R and is retried at the next FRAME cycle.
REQ-025 The block SHALL emit at most one event per frame, and multiple simultaneous changes SHALL be reported in ascending index over successive frames.
REQ-026 key_valid, key_code and key_release SHALL be held stable while key_valid=1 and key_ready=0.
REQ-027 A press followed by a release before the press is reported SHALL produce no events (S equals R again).
REQ-028 With LEGACY_MAP=1, row 0 SHALL map to codes 1,2,3,10; row 1 to 4,5,6,11; row 2 to 7,8,9,12; row 3 to 15,0,14,13.
REQ-029 multi SHALL be 1 iff popcount(S) > 1, and held SHALL be 1 iff popcount(S) > 0; both update with S.
REQ-030 Event latency SHALL be at most (DEBOUNCE_FRAMES+1) frames plus 1 cycle from a stable column change, with one frame = ROWS*DWELL_CYCLES+1 cycles.

Reset
REQ-031 While rst_n=0: row = all ones, key_valid=0, key_code=0, key_release=0, multi=0, held=0, S=R=frame=0, counters=0.
REQ-032 After rst_n deasserts, the first clk edge SHALL enter DRIVE with r = 0.
REQ-033 Reset mid-frame or mid-handshake SHALL discard the pending event and partial frame.

Structure
REQ-034 The shared package keypad_pkg SHALL hold the 4x4 legend constants (KEY_0..KEY_9, KEY_A..KEY_D, KEY_STAR=15, KEY_HASH=14) and the index-to-legend function.
REQ-035 The frame debouncer (REQ-020/021) SHALL be the sub-module keypad_frame_debounce, parameterised by ROWS*COLS and DEBOUNCE_FRAMES.

Verification (DWELL_CYCLES=4, DEBOUNCE_FRAMES=3, 4x4, LEGACY_MAP=1)
REQ-036 Hold row1/col2 pressed with key_ready=1 -> one event, code 6, release=0, held=1; on release -> code 6, release=1, held=0.
REQ-037 Toggle col0 on row0 every 5 cycles for 60 cycles, then release -> no events.
REQ-038 Press keys 5 and 13 in the same frame -> press for code 5 (index 5) in one frame, code 13 (index 15) in the next frame, multi=1.
REQ-039 Press key 1 with key_ready=0 for 10 frames, then press and release key 2 -> key_valid stays high with code 1; after key_ready=1, key 2 press and release events follow in order.
REQ-040 Assert rst_n=0 while key_valid=1 -> all outputs 0 and row=4'b1111 immediately; after release, no stale event.
REQ-041 In every cycle, assert that row has at most one zero bit, and that key_valid=1 with key_ready=0 holds outputs unchanged next cycle.
